// File: rtl/bus_pkg.sv
`default_nettype none
//==============================================================
// Package : bus_pkg
// Desc    : Shared bus transfer type and size encodings.
// Rev     : 1.0
//==============================================================
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_t;

  typedef enum logic [1:0] {
    TSIZE_BYTE = 2'd0,
    TSIZE_HALF = 2'd1,
    TSIZE_WORD = 2'd2
  } tsize_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_pkg.sv
`default_nettype none
//==============================================================
// Package : ifetch_pkg
// Desc    : Fetch FSM states, buffer entry type and PC helpers.
// Rev     : 1.0
//==============================================================
package ifetch_pkg;

  localparam logic [31:0] c_word_bytes = 32'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } ifetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  function automatic logic [31:0] f_word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_bus_master_if.sv
`default_nettype none
//==============================================================
// Interface : master_bus_if
// Desc      : Single-outstanding request/grant/done system bus.
// Rev       : 1.0
//==============================================================
interface master_bus_if;
  import bus_pkg::*;

  logic        breq;
  logic        bstart;
  logic [31:0] addr;
  tsize_t      tsize;
  ttype_t      ttype;
  logic [31:0] wdata;
  logic        bgnt;
  logic [31:0] rdata;
  logic        bdone;
  logic        berror;

  modport master (
    output breq, bstart, addr, tsize, ttype, wdata,
    input  bgnt, rdata, bdone, berror
  );

  modport slave (
    input  breq, bstart, addr, tsize, ttype, wdata,
    output bgnt, rdata, bdone, berror
  );

endinterface
`default_nettype wire

// File: rtl/ifetch_bus_master_fifo.sv
`default_nettype none
//==============================================================
// Module : ifetch_fifo
// Desc   : Synchronous fetch-entry FIFO with flush; head is registered storage.
// Rev    : 1.0
//==============================================================
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  fetch_entry_t       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_full    = (r_count == c_depth);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_bus_master.sv
`default_nettype none
//==============================================================
// Module : ifetch_bus_master
// Desc   : Sequential instruction fetch with redirect flush and stale-response drain.
// Rev    : 1.0
//==============================================================
module ifetch_bus_master
  import bus_pkg::*;
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  master_bus_if.master        ibus,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr_data,
  output logic [31:0]         instr_pc,
  output logic                instr_fault
);

  localparam int                 c_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  ifetch_state_t      r_state;
  ifetch_state_t      w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic               w_breq;
  logic               w_bstart;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  fetch_entry_t       w_push_entry;
  fetch_entry_t       w_head;
  logic [c_cnt_w-1:0] w_count;
  logic [c_cnt_w-1:0] w_pop_cnt;
  logic [c_cnt_w-1:0] w_cnt_after_push;

  assign w_pop            = !w_empty && instr_ready && !redirect_valid;
  assign w_pop_cnt        = w_pop ? c_one : '0;
  assign w_cnt_after_push = w_count + c_one - w_pop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_breq       = 1'b0;
    w_bstart     = 1'b0;
    w_push       = 1'b0;
    w_push_entry = '{instr: ibus.rdata, pc: r_pc, fault: 1'b0};

    case (r_state)
      IDLE: begin
        if (!w_full || w_pop) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_breq = 1'b1;
        // A grant that coincides with a redirect is not taken, so nothing goes stale.
        if (ibus.bgnt && !redirect_valid) begin
          w_bstart    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_breq = 1'b1;
        if (ibus.bdone) begin
          w_push = 1'b1;
          if (ibus.berror) begin
            w_push_entry.instr = '0;
            w_push_entry.fault = 1'b1;
            w_state_nxt        = HALT;
          end else begin
            w_pc_nxt    = r_pc + c_word_bytes;
            w_state_nxt = (w_cnt_after_push < c_depth) ? REQ : IDLE;
          end
        end
      end
      DRAIN: begin
        w_breq = 1'b1;
        if (ibus.bdone) begin
          w_state_nxt = IDLE;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (redirect_valid) begin
      w_push   = 1'b0;
      w_pc_nxt = f_word_align(redirect_pc);
      case (r_state)
        WAIT, DRAIN: w_state_nxt = ibus.bdone ? IDLE : DRAIN;
        default:     w_state_nxt = IDLE;
      endcase
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign ibus.breq   = w_breq;
  assign ibus.bstart = w_bstart;
  assign ibus.addr   = r_pc;
  assign ibus.tsize  = TSIZE_WORD;
  assign ibus.ttype  = READ;
  assign ibus.wdata  = '0;

  assign instr_valid = !w_empty;
  assign instr_data  = w_empty ? '0 : w_head.instr;
  assign instr_pc    = w_empty ? '0 : w_head.pc;
  assign instr_fault = w_empty ? 1'b0 : w_head.fault;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_bus_master.sv
`default_nettype none
//==============================================================
// Module : tb_ifetch_bus_master
// Desc   : Directed and random fetch checks against a transaction-level model.
// Rev    : 1.0
//==============================================================
module tb_ifetch_bus_master;
  import bus_pkg::*;

  localparam logic [31:0] c_reset_pc = 32'hF000_0000;
  localparam int          c_depth    = 2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;

  master_bus_if ibus ();

  ifetch_bus_master #(
    .RESET_PC   (c_reset_pc),
    .FIFO_DEPTH (c_depth)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ibus           (ibus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  always #5 clk = ~clk;

  // stimulus knobs
  bit          ready_q, redir_q, rand_data;
  logic [31:0] rpc_q, err_addr;
  int          gnt_stall, delay_lo, delay_hi, err_pct;
  // reference model
  exp_t        expq[$];
  logic [31:0] exp_pc, paddr, pdata, last_bstart, stall_addr;
  bit          exp_halted, pending, pstale, perr, last_triple;
  int          pcnt, nbstart, tick_no, idle_cnt, stall_seen;
  int          bst_tick[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic tick();
    bit          comp, redir, pop_now, push_now, bs;
    logic [31:0] bs_addr;
    exp_t        e;
    @(negedge clk);
    redirect_valid = redir_q;
    redirect_pc    = rpc_q;
    instr_ready    = ready_q;
    ibus.bgnt      = ibus.breq && (gnt_stall == 0);
    if (ibus.breq && !pending && gnt_stall > 0) begin
      gnt_stall--;
      stall_seen++;
      if (stall_seen == 1) stall_addr = ibus.addr;
    end
    comp        = pending && (pcnt == 0);
    ibus.bdone  = comp;
    ibus.rdata  = comp ? pdata : 32'h0;
    ibus.berror = comp && perr;
    if (pending && !comp) pcnt--;
    #1;
    redir   = redirect_valid;
    bs      = ibus.bstart;
    bs_addr = ibus.addr;
    if (bs) begin
      chk("bstart_outstanding", {31'b0, pending}, 0);
      chk("bstart_halted", {31'b0, exp_halted}, 0);
      chk("bstart_breq", ibus.breq, 1);
      if (!redir) chk("fetch_addr", bs_addr, exp_pc);
    end
    pop_now     = instr_valid && instr_ready && !redir;
    push_now    = comp && !pstale && !redir;
    last_triple = comp && instr_valid && instr_ready && redir;
    @(posedge clk);
    #1;
    if (redir) begin
      expq.delete();
      exp_pc     = {rpc_q[31:2], 2'b00};
      exp_halted = 1'b0;
    end else begin
      if (pop_now && expq.size() > 0) void'(expq.pop_front());
      if (push_now) begin
        e.instr = perr ? 32'h0 : pdata;
        e.pc    = paddr;
        e.fault = perr;
        expq.push_back(e);
        if (perr) exp_halted = 1'b1;
        else      exp_pc = exp_pc + 32'd4;
      end
    end
    if (comp) pending = 1'b0;
    else if (pending && redir) pstale = 1'b1;
    if (bs) begin
      pending     = 1'b1;
      pstale      = redir;
      paddr       = bs_addr;
      pcnt        = $urandom_range(delay_hi, delay_lo);
      pdata       = rand_data ? $urandom : bs_addr;
      perr        = (bs_addr == err_addr) || ($urandom_range(99, 0) < err_pct);
      last_bstart = bs_addr;
      nbstart++;
      bst_tick.push_back(tick_no);
    end
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, expq.size() != 0});
    if (expq.size() != 0) begin
      chk("instr_pc", instr_pc, expq[0].pc);
      chk("instr_data", instr_data, expq[0].instr);
      chk("instr_fault", {31'b0, instr_fault}, {31'b0, expq[0].fault});
    end
    chk("addr_is_pc", ibus.addr, exp_pc);
    if (pending) chk("breq_busy", ibus.breq, 1);
    else if (exp_halted || expq.size() >= c_depth) chk("breq_parked", ibus.breq, 0);
    if (!redir && !pending && !exp_halted && expq.size() < c_depth && !ibus.breq) idle_cnt++;
    else idle_cnt = 0;
    chk("fetch_stall", {31'b0, idle_cnt >= 2}, 0);
    chk("ttype", ibus.ttype, READ);
    chk("tsize", ibus.tsize, TSIZE_WORD);
    chk("wdata", ibus.wdata, 0);
    tick_no++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_breq", ibus.breq, 0);
    chk("rst_bstart", ibus.bstart, 0);
    chk("rst_addr", ibus.addr, c_reset_pc);
    chk("rst_wdata", ibus.wdata, 0);
    chk("rst_tsize", ibus.tsize, TSIZE_WORD);
    chk("rst_ttype", ibus.ttype, READ);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_data", instr_data, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_fault", instr_fault, 0);
    ibus.bgnt = 1'b0; ibus.bdone = 1'b0; ibus.rdata = '0; ibus.berror = 1'b0;
    redirect_valid = 1'b0; redir_q = 1'b0; gnt_stall = 0;
    expq.delete(); bst_tick.delete();
    exp_pc = c_reset_pc; exp_halted = 1'b0; pending = 1'b0; pstale = 1'b0;
    idle_cnt = 0; nbstart = 0; tick_no = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("release_breq", ibus.breq, 0);
  endtask

  initial begin
    int n;
    ready_q = 1'b1; redir_q = 1'b0; rand_data = 1'b0; rpc_q = '0; err_addr = 32'h1;
    gnt_stall = 0; delay_lo = 0; delay_hi = 0; err_pct = 0;
    ibus.bgnt = 1'b0; ibus.bdone = 1'b0; ibus.rdata = '0; ibus.berror = 1'b0;

    // Sequential fetch after reset, addr-as-data memory
    do_reset();
    tick();
    chk("first_breq", ibus.breq, 1);
    for (int k = 0; k < 20 && nbstart < 3; k++) tick();
    if (nbstart < 3) timeout("seq_fetch");
    else begin
      chk("throughput", bst_tick[2] - bst_tick[0], 4);
      chk("seq_third_addr", last_bstart, 32'hF000_0008);
    end
    repeat (2) tick();

    // Decode stalled: two words buffered, bus parked
    ready_q = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("buffered_fetches", nbstart, 2);
    chk("parked_breq", ibus.breq, 0);
    chk("buffered_head_pc", instr_pc, 32'hF000_0000);
    ready_q = 1'b1;
    for (int k = 0; k < 20 && nbstart < 3; k++) tick();
    if (nbstart < 3) timeout("resume");
    else chk("resume_addr", last_bstart, 32'hF000_0008);

    // Grant withheld for three REQ cycles
    stall_seen = 0;
    gnt_stall  = 3;
    for (int k = 0; k < 20 && nbstart < 4; k++) tick();
    if (nbstart < 4) timeout("grant_stall");
    else begin
      chk("stall_cycles", stall_seen, 3);
      chk("stall_addr", stall_addr, 32'hF000_000C);
      chk("stall_grant_addr", last_bstart, 32'hF000_000C);
    end

    // Redirect while waiting on a slow response
    do_reset();
    delay_lo = 2; delay_hi = 2;
    for (int k = 0; k < 10 && !pending; k++) tick();
    tick();
    redir_q = 1'b1; rpc_q = 32'hF000_0102;
    tick();
    redir_q = 1'b0; delay_lo = 0; delay_hi = 0;
    tick();
    chk("drain_no_push", instr_valid, 0);
    for (int k = 0; k < 20 && nbstart < 2; k++) tick();
    if (nbstart < 2) timeout("redirect_refetch");
    else chk("redirect_addr", last_bstart, 32'hF000_0100);
    repeat (3) tick();

    // Bus error halts fetch until redirected
    do_reset();
    err_addr = 32'hF000_000C;
    for (int k = 0; k < 40 && !exp_halted; k++) tick();
    if (!exp_halted) timeout("berror");
    else begin
      chk("fault_valid", instr_valid, 1);
      chk("fault_flag", instr_fault, 1);
      chk("fault_pc", instr_pc, 32'hF000_000C);
      chk("fault_data", instr_data, 0);
    end
    n = nbstart;
    repeat (10) tick();
    chk("halt_no_fetch", nbstart, n);
    chk("halt_breq", ibus.breq, 0);
    err_addr = 32'h1;
    redir_q = 1'b1; rpc_q = 32'hF000_0000;
    tick();
    redir_q = 1'b0;
    for (int k = 0; k < 20 && nbstart == n; k++) tick();
    if (nbstart == n) timeout("halt_restart");
    else chk("halt_restart_addr", last_bstart, 32'hF000_0000);

    // Redirect coinciding with bdone and a pop
    ready_q = 1'b0;
    do_reset();
    for (int k = 0; k < 20 && !(pending && pcnt == 0 && instr_valid); k++) tick();
    ready_q = 1'b1; redir_q = 1'b1; rpc_q = 32'hF000_0200;
    tick();
    redir_q = 1'b0;
    chk("triple_event", {31'b0, last_triple}, 1);
    chk("triple_flush", instr_valid, 0);
    n = nbstart;
    for (int k = 0; k < 20 && nbstart == n; k++) tick();
    if (nbstart == n) timeout("triple_refetch");
    else chk("triple_addr", last_bstart, 32'hF000_0200);

    // Randomised traffic, including a reset mid-stream and wraparound
    rand_data = 1'b1; delay_lo = 0; delay_hi = 3; err_pct = 4;
    do_reset();
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      ready_q = ($urandom_range(3, 0) != 0);
      if (gnt_stall == 0 && $urandom_range(7, 0) == 0) gnt_stall = $urandom_range(3, 1);
      redir_q = exp_halted ? ($urandom_range(9, 0) < 3) : ($urandom_range(99, 0) < 3);
      if ($urandom_range(9, 0) == 0) rpc_q = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else rpc_q = {4'hF, 28'($urandom)};
      if (i == 1500) begin
        n = n + nbstart;
        do_reset();
      end
      tick();
    end
    redir_q = 1'b0;
    chk("random_progress", {31'b0, (n + nbstart) > 300}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_bus_master.md
Name: ifetch_bus_master

Overview:
- Instruction-fetch bus master for core0.
- Generates sequential word fetches on the ibus master port and sits directly upstream of the ibus interconnect.
- Buffers returned instructions in a small FIFO for decode.
- Supports pipeline redirects (branch/trap) and discards any in-flight response made stale by a redirect.

Parameters:
- RESET_PC, 32'hF000_0000: first fetch address after reset; lies in the 0xF memory region.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ibus  master_bus_if.master  -  drives breq, bstart, addr, tsize, ttype, wdata; samples bgnt, rdata, bdone, berror.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode accepts head when valid and ready are both high.
- instr_data  out  32  fetched instruction word.
- instr_pc  out  32  address of instr_data.
- instr_fault  out  1  head entry came from a berror response; instr_data is 0.

Behaviour:
- Reset values:
  - State IDLE, pc=RESET_PC, FIFO empty.
  - breq=0, bstart=0, addr=RESET_PC, wdata=0, tsize=word, ttype=READ.
  - instr_valid=0, instr_data=0, instr_pc=0, instr_fault=0.
- Constant bus outputs: ttype=READ and tsize=word always; wdata=0 always.
- addr=pc in every state.
- IDLE:
  - breq=0.
  - Go to REQ next cycle if FIFO count < FIFO_DEPTH (after this cycle's pop).
  - Otherwise stay in IDLE.
- REQ:
  - breq=1.
  - If bgnt=1: bstart=1 for this cycle only, next state WAIT.
  - If bgnt=0: stay in REQ; addr stays stable.
- WAIT:
  - breq=1, bstart=0, addr held.
  - On bdone=1: push {rdata, pc, berror}.
    - If berror=1: push {0, pc, 1}, next state HALT, pc unchanged.
    - Otherwise: pc += 4 (wraps mod 2^32), next state REQ if a FIFO slot remains after this push/pop, else IDLE.
- DRAIN:
  - breq=1, waits for bdone of a stale transaction.
  - On bdone, discard rdata/berror (no push) and go to IDLE.
- HALT:
  - breq=0, no fetch.
  - Leaves only on redirect.
- Redirect (highest priority, any state):
  - FIFO flushed next cycle; a same-cycle pop is ignored.
  - pc = {redirect_pc[31:2], 2'b00}.
  - From IDLE, REQ or HALT: next state IDLE. A REQ abandoned before grant drops breq.
  - From WAIT with bdone=0: next state DRAIN, pc updated now.
  - From WAIT with bdone=1: response discarded, next state IDLE.
  - From DRAIN: pc updated, remain in DRAIN until bdone.
- Latency:
  - First breq rises in the 2nd cycle after rst_n deasserts (IDLE then REQ).
  - With bgnt=breq and single-cycle bdone, steady-state throughput is one word per 2 cycles (REQ, WAIT).
  - Data is visible on instr_* the cycle after bdone.
- FIFO rules:
  - Simultaneous push and pop allowed when full or empty.
  - Never push when full; guaranteed because REQ is only entered with a free slot and only one transaction is outstanding.
  - Head outputs are registered (FIFO storage), not combinational from rdata.
- Outstanding limit: at most one bus transaction; bstart is never asserted outside REQ.
- Reset mid-transaction: all state cleared asynchronously; breq drops immediately.

Decomposition:
- ifetch_pkg:
  - ifetch_state_t enum {IDLE, REQ, WAIT, DRAIN, HALT}.
  - fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc; logic fault}.
- Bus types ttype_t (READ/WRITE) and the word tsize encoding come from the existing shared bus package.
- Sub-module ifetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH parameter, push/pop, flush, count, full/empty. Same clk/rst_n.

Test Plan:
- Reset release with bgnt=breq, 1-cycle bdone memory returning addr-as-data -> fetches at F000_0000, F000_0004, F000_0008; instr_pc/instr_data match; bstart pulses exactly once per fetch.
- Hold instr_ready=0 -> exactly 2 words buffered, then breq stays 0 in IDLE; raise instr_ready -> fetching resumes at F000_0008.
- bgnt held 0 for 3 cycles in REQ -> breq=1 and addr stable throughout, bstart only in the grant cycle.
- Redirect to F000_0100 while in WAIT with bdone delayed 2 cycles -> stale word dropped, FIFO empty, next bstart at addr F000_0100.
- berror on fetch of F000_000C -> entry with instr_fault=1, instr_pc=F000_000C; no further breq until redirect to F000_0000 restarts fetching.
- Redirect asserted in the same cycle as bdone and a pop -> no push, FIFO empty next cycle, next fetch at redirect_pc.
